icache_ctl: RTL and testbench



---
 rtl/icache_pkg.sv | 50 +++++
 rtl/icache_array.sv | 52 +++++
 rtl/icache_ctl.sv | 207 ++++++++++++++++++++
 tb/tb_icache_ctl.sv | 477 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// icache_pkg: shared state encoding, width derivations and word-address field
// slicing for the instruction cache controller.
package icache_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MISS_REQ  = 2'd1,
    MISS_FILL = 2'd2,
    MISS_RESP = 2'd3
  } ic_state_e;

  // Fetch addresses are word addresses (byte address bits [31:2]).
  localparam int unsigned WADDR_W = 30;

  function automatic int unsigned calc_idx_w(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned calc_off_w(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

  function automatic int unsigned calc_tag_w(input int unsigned sets,
                                             input int unsigned line_words);
    return WADDR_W - $clog2(sets) - $clog2(line_words);
  endfunction

  function automatic logic [WADDR_W-1:0] addr_off(input logic [WADDR_W-1:0] a,
                                                  input int unsigned       off_w);
    return a & ((WADDR_W'(1) << off_w) - WADDR_W'(1));
  endfunction

  function automatic logic [WADDR_W-1:0] addr_idx(input logic [WADDR_W-1:0] a,
                                                  input int unsigned       off_w,
                                                  input int unsigned       idx_w);
    return (a >> off_w) & ((WADDR_W'(1) << idx_w) - WADDR_W'(1));
  endfunction

  function automatic logic [WADDR_W-1:0] addr_tag(input logic [WADDR_W-1:0] a,
                                                  input int unsigned       off_w,
                                                  input int unsigned       idx_w);
    return a >> (off_w + idx_w);
  endfunction

  function automatic logic [WADDR_W-1:0] addr_line(input logic [WADDR_W-1:0] a,
                                                   input int unsigned       off_w);
    return a >> off_w;
  endfunction

endpackage

// File: rtl/icache_array.sv
// icache_array: tag/valid/data storage for the direct-mapped cache.
// Combinational read, single write port; valid bits clear on reset.
module icache_array
  import icache_pkg::*;
#(
  parameter int unsigned SETS       = 64,
  parameter int unsigned LINE_WORDS = 8
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [calc_idx_w(SETS)-1:0]               rd_idx_i,
  input  logic [calc_off_w(LINE_WORDS)-1:0]         rd_off_i,
  output logic [calc_tag_w(SETS, LINE_WORDS)-1:0]   rd_tag_o,
  output logic                                      rd_valid_o,
  output logic [31:0]                               rd_data_o,
  input  logic                                      wr_word_en_i,
  input  logic [calc_idx_w(SETS)-1:0]               wr_idx_i,
  input  logic [calc_off_w(LINE_WORDS)-1:0]         wr_off_i,
  input  logic [31:0]                               wr_data_i,
  input  logic                                      wr_line_en_i,
  input  logic [calc_tag_w(SETS, LINE_WORDS)-1:0]   wr_tag_i,
  input  logic                                      wr_valid_i
);

  localparam int unsigned TAG_W = calc_tag_w(SETS, LINE_WORDS);

  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS*LINE_WORDS];
  logic [SETS-1:0]  valid_q;

  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_data_o  = data_q[{rd_idx_i, rd_off_i}];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (wr_line_en_i) begin
      valid_q[wr_idx_i] <= wr_valid_i;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_word_en_i) begin
      data_q[{wr_idx_i, wr_off_i}] <= wr_data_i;
    end
    if (wr_line_en_i) begin
      tag_q[wr_idx_i] <= wr_tag_i;
    end
  end

endmodule

// File: rtl/icache_ctl.sv
// icache_ctl: direct-mapped instruction cache controller between fetch and the
// memory bus. Define ICACHE_PERF_EN to add hit/miss counter outputs.
module icache_ctl
  import icache_pkg::*;
#(
  parameter int unsigned SETS       = 64,
  parameter int unsigned LINE_WORDS = 8
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         fetch_ic_req,
  input  logic [WADDR_W-1:0]                           fetch_ic_addr,
  input  logic                                         fetch_ic_flush,
  output logic                                         icache_ready,
  output logic                                         icache_valid,
  output logic                                         icache_error,
  output logic [31:0]                                  icache_data,
  output logic                                         icache_mem_req,
  output logic [WADDR_W-calc_off_w(LINE_WORDS)-1:0]    icache_mem_addr,
  input  logic                                         mem_icache_ready,
  input  logic                                         mem_icache_valid,
  input  logic                                         mem_icache_error,
  input  logic [31:0]                                  mem_icache_data
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]                                  icache_hit_cnt,
  output logic [31:0]                                  icache_miss_cnt
`endif
);

  localparam int unsigned IDX_W  = calc_idx_w(SETS);
  localparam int unsigned OFF_W  = calc_off_w(LINE_WORDS);
  localparam int unsigned TAG_W  = calc_tag_w(SETS, LINE_WORDS);
  localparam int unsigned LINE_W = WADDR_W - OFF_W;

  ic_state_e          state_q, state_d;
  logic               req_vld_q, req_vld_d;
  logic [WADDR_W-1:0] req_addr_q, req_addr_d;
  logic               kill_q, kill_d;
  logic               err_q, err_d;
  logic [OFF_W-1:0]   cnt_q, cnt_d;

  logic [IDX_W-1:0]   req_idx;
  logic [OFF_W-1:0]   req_off;
  logic [TAG_W-1:0]   req_tag;
  logic [TAG_W-1:0]   arr_tag;
  logic               arr_valid;
  logic [31:0]        arr_data;
  logic               lookup_hit;
  logic               lookup_miss;
  logic               accept;
  logic               fill_err;
  logic               wr_word_en;
  logic               wr_line_en;
  logic               wr_valid;

  assign req_idx = IDX_W'(addr_idx(req_addr_q, OFF_W, IDX_W));
  assign req_off = OFF_W'(addr_off(req_addr_q, OFF_W));
  assign req_tag = TAG_W'(addr_tag(req_addr_q, OFF_W, IDX_W));

  icache_array #(
    .SETS       (SETS),
    .LINE_WORDS (LINE_WORDS)
  ) u_array (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_idx_i     (req_idx),
    .rd_off_i     (req_off),
    .rd_tag_o     (arr_tag),
    .rd_valid_o   (arr_valid),
    .rd_data_o    (arr_data),
    .wr_word_en_i (wr_word_en),
    .wr_idx_i     (req_idx),
    .wr_off_i     (cnt_q),
    .wr_data_i    (mem_icache_data),
    .wr_line_en_i (wr_line_en),
    .wr_tag_i     (req_tag),
    .wr_valid_i   (wr_valid)
  );

  assign lookup_hit  = req_vld_q & arr_valid & (arr_tag == req_tag);
  assign lookup_miss = req_vld_q & ~lookup_hit;

  // A pending miss blocks acceptance in the very cycle it is detected.
  assign icache_ready    = (state_q == RUN) & ~lookup_miss;
  assign accept          = fetch_ic_req & icache_ready;
  assign fill_err        = err_q | mem_icache_error;
  assign icache_data     = arr_data;
  assign icache_mem_addr = LINE_W'(addr_line(req_addr_q, OFF_W));

  always_comb begin
    state_d        = state_q;
    req_vld_d      = req_vld_q;
    req_addr_d     = req_addr_q;
    kill_d         = kill_q;
    err_d          = err_q;
    cnt_d          = cnt_q;
    icache_valid   = 1'b0;
    icache_error   = 1'b0;
    icache_mem_req = 1'b0;
    wr_word_en     = 1'b0;
    wr_line_en     = 1'b0;
    wr_valid       = 1'b0;

    case (state_q)
      RUN: begin
        icache_valid = lookup_hit;
        // Flush drops the held request (and any new accept); a hit being
        // answered this cycle is still delivered.
        if (fetch_ic_flush) begin
          req_vld_d = 1'b0;
        end else if (lookup_miss) begin
          state_d = MISS_REQ;
        end else begin
          req_vld_d = accept;
          if (accept) begin
            req_addr_d = fetch_ic_addr;
          end
        end
      end

      MISS_REQ: begin
        icache_mem_req = 1'b1;
        if (fetch_ic_flush) begin
          kill_d = 1'b1;
        end
        if (mem_icache_ready) begin
          state_d = MISS_FILL;
          cnt_d   = '0;
        end
      end

      MISS_FILL: begin
        if (fetch_ic_flush) begin
          kill_d = 1'b1;
        end
        if (mem_icache_valid) begin
          wr_word_en = 1'b1;
          err_d      = fill_err;
          cnt_d      = cnt_q + 1'b1;
          if (cnt_q == OFF_W'(LINE_WORDS - 1)) begin
            wr_line_en = 1'b1;
            wr_valid   = ~fill_err;
            state_d    = MISS_RESP;
          end
        end
      end

      MISS_RESP: begin
        icache_valid = ~kill_q;
        icache_error = err_q;
        err_d        = 1'b0;
        kill_d       = 1'b0;
        req_vld_d    = 1'b0;
        state_d      = RUN;
      end

      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RUN;
      req_vld_q  <= 1'b0;
      req_addr_q <= '0;
      kill_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      req_vld_q  <= req_vld_d;
      req_addr_q <= req_addr_d;
      kill_q     <= kill_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef ICACHE_PERF_EN
  logic        hit_evt;
  logic        miss_evt;
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  assign hit_evt  = (state_q == RUN) & lookup_hit;
  assign miss_evt = (state_q == RUN) & lookup_miss & ~fetch_ic_flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_evt) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (miss_evt) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign icache_hit_cnt  = hit_cnt_q;
  assign icache_miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_ctl.sv
// tb_icache_ctl: self-checking bench for icache_ctl with a randomized bus
// responder and a set-level reference model of cache contents.
module tb_icache_ctl;

  localparam int unsigned SETS     = 64;
  localparam int unsigned LW       = 8;
  localparam int          MISS_MIN = LW + 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_ic_req;
  logic [29:0] fetch_ic_addr;
  logic        fetch_ic_flush;
  logic        icache_ready;
  logic        icache_valid;
  logic        icache_error;
  logic [31:0] icache_data;
  logic        icache_mem_req;
  logic [26:0] icache_mem_addr;
  logic        mem_icache_ready;
  logic        mem_icache_valid;
  logic        mem_icache_error;
  logic [31:0] mem_icache_data;
`ifdef ICACHE_PERF_EN
  logic [31:0] icache_hit_cnt;
  logic [31:0] icache_miss_cnt;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  icache_ctl #(
    .SETS       (SETS),
    .LINE_WORDS (LW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .fetch_ic_req     (fetch_ic_req),
    .fetch_ic_addr    (fetch_ic_addr),
    .fetch_ic_flush   (fetch_ic_flush),
    .icache_ready     (icache_ready),
    .icache_valid     (icache_valid),
    .icache_error     (icache_error),
    .icache_data      (icache_data),
    .icache_mem_req   (icache_mem_req),
    .icache_mem_addr  (icache_mem_addr),
    .mem_icache_ready (mem_icache_ready),
    .mem_icache_valid (mem_icache_valid),
    .mem_icache_error (mem_icache_error),
    .mem_icache_data  (mem_icache_data)
`ifdef ICACHE_PERF_EN
    ,
    .icache_hit_cnt   (icache_hit_cnt),
    .icache_miss_cnt  (icache_miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Backing memory: every word address has a distinct value; line 0x80 holds 0x13+i.
  function automatic logic [31:0] mem_word(input logic [29:0] wa);
    return 32'h13 + 32'(wa) - 32'h400;
  endfunction

  // Reference model: which line each set holds and whether it is usable.
  int unsigned m_line [SETS];
  bit          m_vld  [SETS];
  int unsigned m_hits;
  int unsigned m_misses;

  function automatic void model_reset();
    for (int unsigned s = 0; s < SETS; s++) m_vld[s] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
  endfunction

  function automatic bit model_access(input logic [29:0] wa, input bit err);
    int unsigned ln;
    int unsigned s;
    ln = 32'(wa) / LW;
    s  = ln % SETS;
    if (m_vld[s] && m_line[s] == ln) begin
      m_hits++;
      return 1'b1;
    end
    m_misses++;
    m_line[s] = ln;
    m_vld[s]  = !err;
    return 1'b0;
  endfunction

  // Bus responder: randomly delayed accept, beats with random gaps.
  bit          inj_en;
  logic [26:0] inj_line;
  int          inj_beat;
  logic [26:0] last_line;
  int          beat_no;

  initial begin
    int          left;
    logic [26:0] line;
    mem_icache_ready = 1'b0;
    mem_icache_valid = 1'b0;
    mem_icache_error = 1'b0;
    mem_icache_data  = '0;
    left      = 0;
    line      = '0;
    last_line = '0;
    beat_no   = -1;
    forever begin
      @(posedge clk);
      #1;
      mem_icache_ready = 1'b0;
      mem_icache_valid = 1'b0;
      mem_icache_error = 1'b0;
      beat_no          = -1;
      if (!rst_n) begin
        left = 0;
      end else if (left > 0) begin
        if ($urandom_range(3) != 0) begin
          beat_no          = LW - left;
          mem_icache_valid = 1'b1;
          mem_icache_data  = mem_word((30'(line) << 3) | 30'(beat_no));
          if (inj_en && line == inj_line && beat_no == inj_beat) begin
            mem_icache_error = 1'b1;
            inj_en           = 1'b0;
          end
          left--;
        end
      end else if (icache_mem_req && $urandom_range(1) == 0) begin
        mem_icache_ready = 1'b1;
        line             = icache_mem_addr;
        last_line        = icache_mem_addr;
        left             = LW;
      end
    end
  end

  // One request: wait for ready, present it for one cycle, wait for the response.
  task automatic do_access(input logic [29:0] wa, output bit got, output logic [31:0] d,
                           output bit e, output int lat, output bit rdy1);
    int w;
    got  = 1'b0;
    d    = '0;
    e    = 1'b0;
    rdy1 = 1'b1;
    w    = 0;
    while (!icache_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    fetch_ic_req  = 1'b1;
    fetch_ic_addr = wa;
    @(negedge clk);
    fetch_ic_req = 1'b0;
    lat  = 1;
    rdy1 = icache_ready;
    while (!icache_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (icache_valid) begin
      got = 1'b1;
      d   = icache_data;
      e   = icache_error;
    end
  endtask

  task automatic wait_ready();
    for (int w = 0; w < 200 && !icache_ready; w++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_reset();
    checks++;
    if (icache_ready !== 1'b1 || icache_valid !== 1'b0 || icache_mem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b valid=%b mem_req=%b, required 1 0 0",
               icache_ready, icache_valid, icache_mem_req);
    end
`ifdef ICACHE_PERF_EN
    checks++;
    if (icache_hit_cnt !== 32'd0 || icache_miss_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_counters: hit=%0d miss=%0d, required 0 0", icache_hit_cnt, icache_miss_cnt);
    end
`endif
  endtask

  task automatic test_cold_miss();
    bit got, e, rdy1, exp_hit;
    logic [31:0] d;
    int lat;
    exp_hit = model_access(30'h400, 1'b0);
    do_access(30'h400, got, d, e, lat, rdy1);
    checks++;
    if (rdy1 !== 1'b0) begin
      errors++;
      $display("FAIL cold_ready_drop: ready=%b after miss lookup, required 0", rdy1);
    end
    checks++;
    if (!got || d !== 32'h13 || e !== 1'b0) begin
      errors++;
      $display("FAIL cold_resp: got=%b data=%h err=%b, required 1 00000013 0", got, d, e);
    end
    checks++;
    if (exp_hit || lat < MISS_MIN) begin
      errors++;
      $display("FAIL cold_latency: lat=%0d model_hit=%b, required miss with lat>=%0d", lat, exp_hit, MISS_MIN);
    end
    checks++;
    if (last_line !== 27'h80) begin
      errors++;
      $display("FAIL cold_mem_addr: line=%h, required 0000080", last_line);
    end
    exp_hit = model_access(30'h401, 1'b0);
    do_access(30'h401, got, d, e, lat, rdy1);
    checks++;
    if (!exp_hit || !got || lat != 1 || d !== 32'h14 || e !== 1'b0) begin
      errors++;
      $display("FAIL cold_then_hit: got=%b lat=%0d data=%h err=%b, required 1 1 00000014 0", got, lat, d, e);
    end
  endtask

  task automatic test_back_to_back();
    bit h;
    wait_ready();
    fetch_ic_req  = 1'b1;
    fetch_ic_addr = 30'h400;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      h = model_access(30'(30'h400 + i - 1), 1'b0);
      checks++;
      if (!h || icache_valid !== 1'b1 || icache_ready !== 1'b1 ||
          icache_data !== mem_word(30'(30'h400 + i - 1))) begin
        errors++;
        $display("FAIL b2b_word%0d: valid=%b ready=%b data=%h, required 1 1 %h",
                 i - 1, icache_valid, icache_ready, icache_data, mem_word(30'(30'h400 + i - 1)));
      end
      if (i < 8) fetch_ic_addr = 30'(30'h400 + i);
      else fetch_ic_req = 1'b0;
    end
  endtask

  task automatic test_flush_hit();
    bit h;
    wait_ready();
    h = model_access(30'h400, 1'b0);
    fetch_ic_req  = 1'b1;
    fetch_ic_addr = 30'h400;
    @(negedge clk);
    checks++;
    if (!h || icache_valid !== 1'b1 || icache_data !== 32'h13) begin
      errors++;
      $display("FAIL flush_hit_delivered: valid=%b data=%h, required 1 00000013", icache_valid, icache_data);
    end
    fetch_ic_flush = 1'b1;
    fetch_ic_addr  = 30'h401;
    @(negedge clk);
    fetch_ic_flush = 1'b0;
    fetch_ic_req   = 1'b0;
    checks++;
    if (icache_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_hit_killed: valid=%b, required 0", icache_valid);
    end
    @(negedge clk);
    checks++;
    if (icache_valid !== 1'b0 || icache_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_hit_idle: valid=%b ready=%b, required 0 1", icache_valid, icache_ready);
    end
  endtask

  task automatic test_conflict();
    bit got, e, rdy1, exp_hit;
    logic [31:0] d;
    int lat;
    exp_hit = model_access(30'h600, 1'b0);
    do_access(30'h600, got, d, e, lat, rdy1);
    checks++;
    if (exp_hit || !got || lat < MISS_MIN || d !== mem_word(30'h600) || last_line !== 27'hC0) begin
      errors++;
      $display("FAIL conflict_fill: got=%b lat=%0d data=%h line=%h, required miss %h line 00000c0",
               got, lat, d, last_line, mem_word(30'h600));
    end
    exp_hit = model_access(30'h400, 1'b0);
    do_access(30'h400, got, d, e, lat, rdy1);
    checks++;
    if (exp_hit || !got || lat < MISS_MIN || d !== 32'h13) begin
      errors++;
      $display("FAIL conflict_refetch: got=%b lat=%0d data=%h, required miss 00000013", got, lat, d);
    end
  endtask

  task automatic test_flush_fill();
    bit got, e, rdy1, exp_hit, flushed, seen;
    logic [31:0] d;
    int lat;
    exp_hit = model_access(30'h600, 1'b0);
    do_access(30'h600, got, d, e, lat, rdy1);
    exp_hit = model_access(30'h400, 1'b0);
    wait_ready();
    fetch_ic_req  = 1'b1;
    fetch_ic_addr = 30'h400;
    @(negedge clk);
    fetch_ic_req = 1'b0;
    flushed = 1'b0;
    seen    = 1'b0;
    for (int w = 0; w < 200; w++) begin
      if (!flushed && mem_icache_valid && beat_no == 3) begin
        fetch_ic_flush = 1'b1;
        flushed        = 1'b1;
      end
      @(negedge clk);
      fetch_ic_flush = 1'b0;
      if (icache_valid) seen = 1'b1;
      if (flushed && icache_ready) break;
    end
    checks++;
    if (exp_hit || !flushed || seen || icache_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_fill_suppress: flushed=%b valid_seen=%b ready=%b, required 1 0 1",
               flushed, seen, icache_ready);
    end
    exp_hit = model_access(30'h400, 1'b0);
    do_access(30'h400, got, d, e, lat, rdy1);
    checks++;
    if (!exp_hit || !got || lat != 1 || d !== 32'h13) begin
      errors++;
      $display("FAIL flush_fill_installed: got=%b lat=%0d data=%h, required hit lat 1 00000013", got, lat, d);
    end
  endtask

  task automatic test_bus_error();
    bit got, e, rdy1, exp_hit;
    logic [31:0] d;
    int lat;
    inj_line = 27'h100;
    inj_beat = 5;
    inj_en   = 1'b1;
    exp_hit  = model_access(30'h803, 1'b1);
    do_access(30'h803, got, d, e, lat, rdy1);
    inj_en = 1'b0;
    checks++;
    if (exp_hit || !got || e !== 1'b1 || d !== mem_word(30'h803) || lat < MISS_MIN) begin
      errors++;
      $display("FAIL bus_error_resp: got=%b err=%b data=%h lat=%0d, required 1 1 %h miss",
               got, e, d, lat, mem_word(30'h803));
    end
    exp_hit = model_access(30'h803, 1'b0);
    do_access(30'h803, got, d, e, lat, rdy1);
    checks++;
    if (exp_hit || !got || e !== 1'b0 || lat < MISS_MIN) begin
      errors++;
      $display("FAIL bus_error_remiss: got=%b err=%b lat=%0d, required miss again err 0", got, e, lat);
    end
    exp_hit = model_access(30'h805, 1'b0);
    do_access(30'h805, got, d, e, lat, rdy1);
    checks++;
    if (!exp_hit || !got || lat != 1 || d !== mem_word(30'h805)) begin
      errors++;
      $display("FAIL bus_error_refilled: got=%b lat=%0d data=%h, required hit %h", got, lat, d, mem_word(30'h805));
    end
  endtask

  task automatic test_random();
    logic [29:0] wa;
    logic [31:0] d;
    bit inj, exp_hit, got, e, rdy1;
    int lat;
    for (int n = 0; n < 80; n++) begin
      wa  = 30'(($urandom_range(3) << 9) | ($urandom_range(3) << 3) | $urandom_range(7));
      inj = ($urandom_range(5) == 0);
      if (inj) begin
        inj_line = 27'(wa >> 3);
        inj_beat = $urandom_range(LW - 1);
        inj_en   = 1'b1;
      end
      exp_hit = model_access(wa, inj);
      do_access(wa, got, d, e, lat, rdy1);
      inj_en = 1'b0;
      checks++;
      if (!got || d !== mem_word(wa) || e !== (inj && !exp_hit)) begin
        errors++;
        $display("FAIL rand_resp%0d: addr=%h got=%b data=%h err=%b, required 1 %h %b",
                 n, wa, got, d, e, mem_word(wa), inj && !exp_hit);
      end
      checks++;
      if (exp_hit ? (lat != 1 || rdy1 !== 1'b1) : (lat < MISS_MIN || rdy1 !== 1'b0)) begin
        errors++;
        $display("FAIL rand_timing%0d: addr=%h lat=%0d ready_after=%b, required hit=%b",
                 n, wa, lat, rdy1, exp_hit);
      end
      repeat ($urandom_range(2)) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_fill();
    bit got, e, rdy1, exp_hit, reached;
    logic [31:0] d;
    int lat;
    wait_ready();
    fetch_ic_req  = 1'b1;
    fetch_ic_addr = 30'h228;
    @(negedge clk);
    fetch_ic_req = 1'b0;
    reached = 1'b0;
    for (int w = 0; w < 200 && !reached; w++) begin
      @(negedge clk);
      if (mem_icache_valid && beat_no == 2) reached = 1'b1;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    checks++;
    if (!reached || icache_ready !== 1'b1 || icache_valid !== 1'b0 || icache_mem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_fill: reached=%b ready=%b valid=%b mem_req=%b, required 1 1 0 0",
               reached, icache_ready, icache_valid, icache_mem_req);
    end
    exp_hit = model_access(30'h228, 1'b0);
    do_access(30'h228, got, d, e, lat, rdy1);
    checks++;
    if (exp_hit || !got || lat < MISS_MIN || d !== mem_word(30'h228)) begin
      errors++;
      $display("FAIL reset_abandoned_line: got=%b lat=%0d data=%h, required miss %h", got, lat, d, mem_word(30'h228));
    end
  endtask

`ifdef ICACHE_PERF_EN
  task automatic test_perf_counters();
    @(negedge clk);
    checks++;
    if (icache_hit_cnt !== m_hits || icache_miss_cnt !== m_misses) begin
      errors++;
      $display("FAIL perf_counters: hit=%0d miss=%0d, required %0d %0d",
               icache_hit_cnt, icache_miss_cnt, m_hits, m_misses);
    end
  endtask
`endif

  initial begin
    fetch_ic_req   = 1'b0;
    fetch_ic_addr  = '0;
    fetch_ic_flush = 1'b0;
    inj_en         = 1'b0;
    inj_line       = '0;
    inj_beat       = 0;
    test_reset();
    test_cold_miss();
    test_back_to_back();
    test_flush_hit();
    test_conflict();
    test_flush_fill();
    test_bus_error();
    test_random();
    test_reset_mid_fill();
`ifdef ICACHE_PERF_EN
    test_perf_counters();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
